fetch_unit: RTL

Instruction-fetch stage with integrated IF/ID pipeline register, sitting directly upstream of the hazard/stall controller and the decode stage. It owns the PC, drives a valid/ready instruction bus, and raises `stall_req_o` into the controller's `stall_from_if_i` while a fetch is outstanding. It consumes the controller's `stall_i` vector and `flush_i` redirect to hold, bubble or retarget the front end.

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, valid/ready ibus and IF/ID register
// Optional stall-cycle counter enabled by defining FETCH_PERF_EN.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic [63:0] redirect_pc_i,
    output logic        ibus_valid_o,
    output logic [63:0] ibus_addr_o,
    input  logic        ibus_ready_i,
    input  logic [31:0] ibus_data_i,
    output logic        stall_req_o,
    output logic        ifid_valid_o,
    output logic [63:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic [63:0] perf_if_stall_o
);
    typedef enum logic [1:0] {S_RESET, S_FETCH, S_HOLD, S_DRAIN} state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] req_addr;
    logic [31:0] buf_data;

    logic        hold;
    logic [63:0] redir;
    logic [63:0] pc_inc;
    logic        unused_bits;

    assign hold        = stall_i[0] | stall_i[1];
    assign redir       = {redirect_pc_i[63:2], 2'b00};
    assign pc_inc      = pc + 64'd4;
    assign unused_bits = ^{stall_i[5:2], redirect_pc_i[1:0]};

    // Bus outputs come only from state and ibus_ready_i, never from stall_i/flush_i.
    assign ibus_valid_o = (state == S_FETCH) || (state == S_DRAIN);
    assign ibus_addr_o  = req_addr;
    assign stall_req_o  = ((state == S_FETCH) && !ibus_ready_i) || (state == S_DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_RESET;
            pc           <= RESET_PC;
            req_addr     <= 64'd0;
            buf_data     <= 32'd0;
            ifid_valid_o <= 1'b0;
            ifid_pc_o    <= 64'd0;
            ifid_instr_o <= 32'd0;
        end else begin
            case (state)
                S_RESET: begin
                    state    <= S_FETCH;
                    pc       <= flush_i ? redir : pc;
                    req_addr <= flush_i ? redir : pc;
                end
                S_FETCH: begin
                    if (ibus_ready_i) begin
                        if (flush_i) begin
                            pc       <= redir;
                            req_addr <= redir;
                        end else if (!hold) begin
                            pc       <= pc_inc;
                            req_addr <= pc_inc;
                        end else begin
                            buf_data <= ibus_data_i;
                            state    <= S_HOLD;
                        end
                    end else if (flush_i) begin
                        // Request stays on the bus at the old address until accepted.
                        pc    <= redir;
                        state <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (flush_i) begin
                        pc       <= redir;
                        req_addr <= redir;
                        state    <= S_FETCH;
                    end else if (!hold) begin
                        pc       <= pc_inc;
                        req_addr <= pc_inc;
                        state    <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (flush_i) begin
                        pc <= redir;
                    end
                    if (ibus_ready_i) begin
                        req_addr <= flush_i ? redir : pc;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_RESET;
            endcase

            if (flush_i) begin
                ifid_valid_o <= 1'b0;
            end else if (!hold) begin
                if (state == S_FETCH && ibus_ready_i) begin
                    ifid_valid_o <= 1'b1;
                    ifid_pc_o    <= pc;
                    ifid_instr_o <= ibus_data_i;
                end else if (state == S_HOLD) begin
                    ifid_valid_o <= 1'b1;
                    ifid_pc_o    <= pc;
                    ifid_instr_o <= buf_data;
                end else begin
                    ifid_valid_o <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [63:0] perf_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cnt <= 64'd0;
        end else if (stall_req_o) begin
            perf_cnt <= perf_cnt + 64'd1;
        end
    end

    assign perf_if_stall_o = perf_cnt;
`else
    assign perf_if_stall_o = 64'd0;
`endif
endmodule
